// File: rtl/ultrasonic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_pkg
// Description : Shared types and constants for the ultrasonic scheduler:
//               FSM state encoding, counter/distance widths and the
//               echo-width to millimetre conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package ultrasonic_pkg;

  // Distance output width in bits; 8191 is reserved for "no echo"
  localparam int DIST_W = 13;
  // Echo / timeout counter width
  localparam int CNT_W  = 22;
  // Sound round trip: mm = cycles * 17 / 10000 at 100 MHz
  localparam int MM_NUM = 17;
  localparam int MM_DEN = 10000;
  // Product width for CNT_W x MM_NUM
  localparam int PROD_W = 27;

  localparam logic [DIST_W-1:0] DIST_TOUT = 13'd8191;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    CALC      = 3'd4,
    TOUT      = 3'd5,
    GUARD     = 3'd6
  } state_e;

  // Convert an echo width in cycles to millimetres (truncating divide).
  // The largest count gives 7130 mm, so the result always fits DIST_W.
  function automatic logic [DIST_W-1:0] echo_to_mm(input logic [CNT_W-1:0] cnt);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(cnt) * PROD_W'(MM_NUM);
    return DIST_W'(prod / PROD_W'(MM_DEN));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ultrasonic_echo_sync.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_echo_sync
// Description : Two-flop synchronizer for one asynchronous echo line, plus
//               registered rising/falling edge strobes. level_o is aligned
//               with the strobes: it is already high in the rise-strobe
//               cycle and already low in the fall-strobe cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_echo_sync
  import ultrasonic_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic echo_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;
  logic rise_q;
  logic fall_q;

  // Synchronize the raw echo and derive single-cycle edge strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ultrasonic_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_scheduler
// Description : Round-robin scheduler sharing one trigger/echo timing engine
//               across N_SENSORS ultrasonic sensors. Fires one sensor per
//               slot, times its echo with a timeout, converts to mm and
//               keeps a per-bay occupied flag with hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENSORS   = 4,
  parameter int TRIG_CYC    = 1000,
  parameter int TIMEOUT_CYC = 3_000_000,
  parameter int SLOT_CYC    = 5_000_000,
  parameter int OCC_MM      = 500,
  parameter int HYST_MM     = 50,
  localparam int IDX_W      = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_ni,
  input  logic                          enable_i,
  input  logic [N_SENSORS-1:0]          echo_i,
  output logic [N_SENSORS-1:0]          trig_o,
  output logic [DIST_W*N_SENSORS-1:0]   dist_mm_o,
  output logic                          dist_valid_o,
  output logic [IDX_W-1:0]              dist_idx_o,
  output logic [N_SENSORS-1:0]          timeout_err_o,
  output logic [N_SENSORS-1:0]          occupied_o,
  output logic                          busy_o
);

  localparam int SLOT_W = $clog2(SLOT_CYC);

  // The slot counter doubles as the trigger-length counter, since it
  // restarts at 0 on every TRIG entry.
  localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]  TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SENSORS - 1);
  localparam logic [DIST_W-1:0] OCC_SET   = DIST_W'(OCC_MM);
  localparam logic [DIST_W-1:0] OCC_CLR   = DIST_W'(OCC_MM + HYST_MM);

  // Synchronized echo level and edge strobes, one per sensor
  logic [N_SENSORS-1:0] echo_lvl;
  logic [N_SENSORS-1:0] echo_rise;
  logic [N_SENSORS-1:0] echo_fall;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sync
    ultrasonic_echo_sync u_sync (
      .clk_i   (sys_clk_i),
      .rst_ni  (sys_rst_ni),
      .echo_i  (echo_i[g]),
      .level_o (echo_lvl[g]),
      .rise_o  (echo_rise[g]),
      .fall_o  (echo_fall[g])
    );
  end

  // FSM state, sensor index and counters
  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]   tout_cnt_q, tout_cnt_d;
  logic [CNT_W-1:0]   echo_cnt_q, echo_cnt_d;

  // Output registers
  logic [N_SENSORS-1:0]             trig_q;
  logic [N_SENSORS-1:0][DIST_W-1:0] dist_q;
  logic                             dist_valid_q;
  logic [IDX_W-1:0]                 dist_idx_q;
  logic [N_SENSORS-1:0]             timeout_err_q;
  logic [N_SENSORS-1:0]             occupied_q;

  // Only the selected sensor's echo is ever looked at
  logic                 sel_lvl;
  logic                 sel_rise;
  logic                 sel_fall;
  logic [N_SENSORS-1:0] sel_onehot;
  logic [DIST_W-1:0]    calc_mm;

  assign sel_lvl    = echo_lvl[idx_q];
  assign sel_rise   = echo_rise[idx_q];
  assign sel_fall   = echo_fall[idx_q];
  assign sel_onehot = N_SENSORS'(1) << idx_q;
  assign calc_mm    = echo_to_mm(echo_cnt_q);

  // State, index and counter registers
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      slot_cnt_q <= '0;
      tout_cnt_q <= '0;
      echo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_cnt_q <= slot_cnt_d;
      tout_cnt_q <= tout_cnt_d;
      echo_cnt_q <= echo_cnt_d;
    end
  end

  // Next-state logic: slot sequencing, echo timing and timeout
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_cnt_d = slot_cnt_q;
    tout_cnt_d = tout_cnt_q;
    echo_cnt_d = echo_cnt_q;

    // The slot counter free-runs for the whole slot so the period is fixed
    if (state_q != IDLE) begin
      slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        slot_cnt_d = '0;
        if (enable_i) begin
          state_d = TRIG;
        end
      end

      TRIG: begin
        if (slot_cnt_q == TRIG_LAST) begin
          state_d    = WAIT_RISE;
          tout_cnt_d = '0;
          echo_cnt_d = '0;
        end
      end

      WAIT_RISE: begin
        tout_cnt_d = tout_cnt_q + CNT_W'(1);
        // The rise strobe cycle already has the level high, so count it
        if (sel_rise) begin
          state_d    = MEASURE;
          echo_cnt_d = CNT_W'(1);
        end else if (tout_cnt_q == TOUT_LAST) begin
          state_d = TOUT;
        end
      end

      MEASURE: begin
        tout_cnt_d = tout_cnt_q + CNT_W'(1);
        if (sel_lvl) begin
          echo_cnt_d = echo_cnt_q + CNT_W'(1);
        end
        if (sel_fall) begin
          state_d = CALC;
        end else if (tout_cnt_q == TOUT_LAST) begin
          state_d = TOUT;
        end
      end

      CALC: state_d = GUARD;

      TOUT: state_d = GUARD;

      GUARD: begin
        if (slot_cnt_q == SLOT_LAST) begin
          slot_cnt_d = '0;
          idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          state_d    = enable_i ? TRIG : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Trigger drive and result write-back (distance, flags, valid strobe)
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      trig_q        <= '0;
      dist_q        <= '0;
      dist_valid_q  <= 1'b0;
      dist_idx_q    <= '0;
      timeout_err_q <= '0;
      occupied_q    <= '0;
    end else begin
      trig_q       <= (state_q == TRIG) ? sel_onehot : '0;
      dist_valid_q <= 1'b0;
      if (state_q == CALC) begin
        dist_q[idx_q]        <= calc_mm;
        timeout_err_q[idx_q] <= 1'b0;
        dist_valid_q         <= 1'b1;
        dist_idx_q           <= idx_q;
        // Between the two thresholds the previous occupancy is kept
        if (calc_mm < OCC_SET) begin
          occupied_q[idx_q] <= 1'b1;
        end else if (calc_mm > OCC_CLR) begin
          occupied_q[idx_q] <= 1'b0;
        end
      end else if (state_q == TOUT) begin
        dist_q[idx_q]        <= DIST_TOUT;
        timeout_err_q[idx_q] <= 1'b1;
        occupied_q[idx_q]    <= 1'b0;
        dist_valid_q         <= 1'b1;
        dist_idx_q           <= idx_q;
      end
    end
  end

  assign trig_o        = trig_q;
  assign dist_mm_o     = dist_q;
  assign dist_valid_o  = dist_valid_q;
  assign dist_idx_o    = dist_idx_q;
  assign timeout_err_o = timeout_err_q;
  assign occupied_o    = occupied_q;
  assign busy_o        = (state_q != IDLE);

endmodule
`default_nettype wire
